auth_multi_channel_driver: RTL and testbench

Parametrised successor to the two-channel (PD/DEBUG) authentication driver. Routes host authentication requests to one of NUM_CH channel drivers using a channel-ID field in the message. Keeps a saturating pending-request counter per channel. Returns channel responses to the host through a round-robin arbiter with a ready/ack handshake.

---
 rtl/auth_multi_channel_driver.sv | 269 ++++++++++++++++++++++++++
 tb/tb_auth_multi_channel_driver.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_multi_channel_driver.sv
// ---------------------------------------------------------------------------
// auth_multi_channel_driver
//
// Routes host authentication requests to one of NUM_CH channel drivers. The
// target is chosen by a channel-ID field inside the request message. Each
// channel has a saturating pending-request counter. Channel responses return
// to the host through a round-robin arbiter with a ready/ack handshake.
//
// The request path and the response path are independent FSMs. Both run
// concurrently.
//
// Optional feature macro: AUTH_TIMEOUT_EN
//   When defined, a held response is dropped after TIMEOUT_CYC cycles without
//   Ack_in, and err_timeout pulses for one cycle.
//   When undefined, err_timeout is constant 0 and no timeout counter exists.
//
// Ports:
//   clk                        system clock, rising edge
//   reset                      asynchronous active-low reset
//   host_msg_in/valid          host request; valid is held until host_msg_ack
//   host_msg_ack               1-cycle pulse: request accepted or dropped
//   ch_msg_out                 last dispatched request, broadcast to all channels
//   ch_msg_ready               one-hot 1-cycle pulse: ch_msg_out is for channel i
//   ch_out_ready               channel i can take a request
//   pending_auth_request       per-channel pending counts, i at [i*PEND_W +: PEND_W]
//   pending_auth_request_erase pulse: channel i finished one request
//   ch_resp_in/valid           channel responses, packed like the counters
//   ch_resp_ack                one-hot 1-cycle grant pulse
//   auth_msg_out/ready         response to host; ready is held until Ack_in
//   Ack_in                     host consumed the response
//   err_bad_ch                 1-cycle pulse: channel ID >= NUM_CH
//   err_timeout                1-cycle pulse: response hold timed out
// ---------------------------------------------------------------------------
module auth_multi_channel_driver #(
  parameter int NUM_CH      = 2,
  parameter int MSG_W       = 64,
  parameter int CH_ID_LSB   = 0,
  parameter int PEND_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MSG_W-1:0]         host_msg_in,
  input  logic                     host_msg_valid,
  output logic                     host_msg_ack,
  output logic [MSG_W-1:0]         ch_msg_out,
  output logic [NUM_CH-1:0]        ch_msg_ready,
  input  logic [NUM_CH-1:0]        ch_out_ready,
  output logic [NUM_CH*PEND_W-1:0] pending_auth_request,
  input  logic [NUM_CH-1:0]        pending_auth_request_erase,
  input  logic [NUM_CH*MSG_W-1:0]  ch_resp_in,
  input  logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [NUM_CH-1:0]        ch_resp_ack,
  output logic [MSG_W-1:0]         auth_msg_out,
  output logic                     auth_msg_ready,
  input  logic                     Ack_in,
  output logic                     err_bad_ch,
  output logic                     err_timeout
);

  // The channel-ID field is at least one bit wide, even when NUM_CH is small.
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic {REQ_IDLE, REQ_DISPATCH} req_state_e;
  typedef enum logic {RSP_IDLE, RSP_HOLD} rsp_state_e;

  // -------------------------------------------------------------------------
  // Request path
  // -------------------------------------------------------------------------
  req_state_e           req_state_q;
  logic [MSG_W-1:0]     req_msg_q;
  logic [CH_W-1:0]      req_id_q;
  logic                 host_msg_ack_q;
  logic                 err_bad_ch_q;
  logic [MSG_W-1:0]     ch_msg_out_q;
  logic [NUM_CH-1:0]    ch_msg_ready_q;

  logic [CH_W-1:0]      host_id;
  logic [NUM_CH-1:0]    id_match;
  logic [NUM_CH-1:0]    ch_full;
  logic [NUM_CH-1:0]    dispatch;
  logic                 id_bad;
  logic                 id_full;

  assign host_id = host_msg_in[CH_ID_LSB +: CH_W];

  // Per-channel decode and saturating pending counters. An ID with no match
  // in 0..NUM_CH-1 is out of range.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PEND_W-1:0] cnt_q;
      logic [PEND_W-1:0] cnt_d;

      assign id_match[gi] = (host_id == CH_W'(gi));
      assign ch_full[gi]  = (cnt_q == PEND_MAX);
      assign dispatch[gi] = (req_state_q == REQ_DISPATCH) &&
                            (req_id_q == CH_W'(gi)) && ch_out_ready[gi];

      // A dispatch and an erase in the same cycle cancel out.
      always_comb begin
        cnt_d = cnt_q;
        if (dispatch[gi] && !pending_auth_request_erase[gi]) begin
          if (cnt_q != PEND_MAX) cnt_d = cnt_q + PEND_W'(1);
        end else if (pending_auth_request_erase[gi] && !dispatch[gi]) begin
          if (cnt_q != '0) cnt_d = cnt_q - PEND_W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign pending_auth_request[gi*PEND_W +: PEND_W] = cnt_q;
    end
  endgenerate

  assign id_bad  = ~|id_match;
  assign id_full = |(id_match & ch_full);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_state_q    <= REQ_IDLE;
      req_msg_q      <= '0;
      req_id_q       <= '0;
      host_msg_ack_q <= 1'b0;
      err_bad_ch_q   <= 1'b0;
      ch_msg_out_q   <= '0;
      ch_msg_ready_q <= '0;
    end else begin
      host_msg_ack_q <= 1'b0;
      err_bad_ch_q   <= 1'b0;
      ch_msg_ready_q <= '0;
      case (req_state_q)
        REQ_IDLE: begin
          // The host may still be holding valid in the cycle its ack is
          // visible; ignore that cycle so one request gives one ack.
          if (host_msg_valid && !host_msg_ack_q) begin
            if (id_bad) begin
              host_msg_ack_q <= 1'b1;
              err_bad_ch_q   <= 1'b1;
            end else if (!id_full) begin
              req_msg_q      <= host_msg_in;
              req_id_q       <= host_id;
              host_msg_ack_q <= 1'b1;
              req_state_q    <= REQ_DISPATCH;
            end
          end
        end
        REQ_DISPATCH: begin
          if (|dispatch) begin
            ch_msg_out_q   <= req_msg_q;
            ch_msg_ready_q <= dispatch;
            req_state_q    <= REQ_IDLE;
          end
        end
        default: req_state_q <= REQ_IDLE;
      endcase
    end
  end

  assign host_msg_ack = host_msg_ack_q;
  assign err_bad_ch   = err_bad_ch_q;
  assign ch_msg_out   = ch_msg_out_q;
  assign ch_msg_ready = ch_msg_ready_q;

  // -------------------------------------------------------------------------
  // Response path
  // -------------------------------------------------------------------------
  rsp_state_e           rsp_state_q;
  logic [CH_W-1:0]      rr_ptr_q;
  logic [MSG_W-1:0]     auth_msg_out_q;
  logic                 auth_msg_ready_q;
  logic [NUM_CH-1:0]    ch_resp_ack_q;

  logic                 grant_found;
  logic [NUM_CH-1:0]    grant_oh;
  logic [MSG_W-1:0]     grant_data;
  logic [CH_W-1:0]      grant_next_ptr;

  // Rotating-priority search: the first valid channel at or above the
  // pointer, wrapping modulo NUM_CH.
  always_comb begin
    int j;
    j              = 0;
    grant_found    = 1'b0;
    grant_oh       = '0;
    grant_data     = '0;
    grant_next_ptr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_found && ch_resp_valid[j]) begin
        grant_found    = 1'b1;
        grant_oh[j]    = 1'b1;
        grant_data     = ch_resp_in[j*MSG_W +: MSG_W];
        grant_next_ptr = CH_W'((j + 1) % NUM_CH);
      end
    end
  end

`ifdef AUTH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_timeout_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_state_q      <= RSP_IDLE;
      rr_ptr_q         <= '0;
      auth_msg_out_q   <= '0;
      auth_msg_ready_q <= 1'b0;
      ch_resp_ack_q    <= '0;
`ifdef AUTH_TIMEOUT_EN
      to_cnt_q         <= '0;
      err_timeout_q    <= 1'b0;
`endif
    end else begin
      ch_resp_ack_q <= '0;
`ifdef AUTH_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
      case (rsp_state_q)
        RSP_IDLE: begin
          if (grant_found) begin
            auth_msg_out_q   <= grant_data;
            ch_resp_ack_q    <= grant_oh;
            rr_ptr_q         <= grant_next_ptr;
            auth_msg_ready_q <= 1'b1;
            rsp_state_q      <= RSP_HOLD;
`ifdef AUTH_TIMEOUT_EN
            to_cnt_q         <= '0;
`endif
          end
        end
        RSP_HOLD: begin
          if (Ack_in) begin
            auth_msg_ready_q <= 1'b0;
            rsp_state_q      <= RSP_IDLE;
          end
`ifdef AUTH_TIMEOUT_EN
          // The TIMEOUT_CYC-th consecutive cycle without Ack_in ends the hold.
          else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            auth_msg_ready_q <= 1'b0;
            auth_msg_out_q   <= '0;
            err_timeout_q    <= 1'b1;
            rsp_state_q      <= RSP_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        default: rsp_state_q <= RSP_IDLE;
      endcase
    end
  end

  assign auth_msg_out   = auth_msg_out_q;
  assign auth_msg_ready = auth_msg_ready_q;
  assign ch_resp_ack    = ch_resp_ack_q;

`ifdef AUTH_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_auth_multi_channel_driver.sv
// Directed sequence with randomized payloads and request choices. A small
// model tracks pending counts, the round-robin pointer and the latest message.
module tb_auth_multi_channel_driver;
  localparam int NCH  = 3;
  localparam int MW   = 32;
  localparam int LSB  = 4;
  localparam int PW   = 2;
  localparam int TO   = 8;
  localparam int CW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [MW-1:0]       host_msg_in;
  logic                host_msg_valid;
  logic                host_msg_ack;
  logic [MW-1:0]       ch_msg_out;
  logic [NCH-1:0]      ch_msg_ready;
  logic [NCH-1:0]      ch_out_ready;
  logic [NCH*PW-1:0]   pending_auth_request;
  logic [NCH-1:0]      pending_auth_request_erase;
  logic [NCH*MW-1:0]   ch_resp_in;
  logic [NCH-1:0]      ch_resp_valid;
  logic [NCH-1:0]      ch_resp_ack;
  logic [MW-1:0]       auth_msg_out;
  logic                auth_msg_ready;
  logic                Ack_in;
  logic                err_bad_ch;
  logic                err_timeout;

  auth_multi_channel_driver #(
    .NUM_CH(NCH), .MSG_W(MW), .CH_ID_LSB(LSB), .PEND_W(PW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .host_msg_in(host_msg_in), .host_msg_valid(host_msg_valid),
    .host_msg_ack(host_msg_ack),
    .ch_msg_out(ch_msg_out), .ch_msg_ready(ch_msg_ready),
    .ch_out_ready(ch_out_ready),
    .pending_auth_request(pending_auth_request),
    .pending_auth_request_erase(pending_auth_request_erase),
    .ch_resp_in(ch_resp_in), .ch_resp_valid(ch_resp_valid),
    .ch_resp_ack(ch_resp_ack),
    .auth_msg_out(auth_msg_out), .auth_msg_ready(auth_msg_ready),
    .Ack_in(Ack_in), .err_bad_ch(err_bad_ch), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            pend [NCH];
  int            rr;
  logic [MW-1:0] last_msg;
  logic [MW-1:0] resp_data [NCH];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*PW-1:0] exp_pend();
    logic [NCH*PW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*PW +: PW] = PW'(pend[i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_msg(input int id, output logic [MW-1:0] m);
    m = $urandom;
    m[LSB +: CW] = CW'(id);
  endtask

  task automatic load_resp();
    for (int i = 0; i < NCH; i++) ch_resp_in[i*MW +: MW] = resp_data[i];
  endtask

  // One request with the target channel ready; the target is never full here.
  task automatic request(input int id);
    logic [MW-1:0] m;
    make_msg(id, m);
    host_msg_in    = m;
    host_msg_valid = 1'b1;
    tick();
    if (id >= NCH) begin
      check("bad_ack", host_msg_ack, 1);
      check("bad_err", err_bad_ch, 1);
      check("bad_no_disp0", ch_msg_ready, 0);
      host_msg_valid = 1'b0;
      tick();
      check("bad_ack_pulse", host_msg_ack, 0);
      check("bad_err_pulse", err_bad_ch, 0);
      check("bad_no_disp1", ch_msg_ready, 0);
      check("bad_pend", pending_auth_request, exp_pend());
      check("bad_msg_hold", ch_msg_out, last_msg);
      $display("[TB] req id=%0d msg=%h dropped", id, m);
    end else begin
      check("req_ack", host_msg_ack, 1);
      check("req_err", err_bad_ch, 0);
      check("req_no_early_disp", ch_msg_ready, 0);
      host_msg_valid = 1'b0;
      tick();
      pend[id]++;
      last_msg = m;
      check("disp_ready", ch_msg_ready, 128'd1 << id);
      check("disp_msg", ch_msg_out, m);
      check("disp_ack_pulse", host_msg_ack, 0);
      check("disp_pend", pending_auth_request, exp_pend());
      $display("[TB] req id=%0d msg=%h dispatched pend=%0d", id, m, pend[id]);
    end
    host_msg_in = $urandom;
  endtask

  task automatic erase_mask(input logic [NCH-1:0] mask);
    pending_auth_request_erase = mask;
    tick();
    pending_auth_request_erase = '0;
    for (int i = 0; i < NCH; i++)
      if (mask[i] && pend[i] > 0) pend[i]--;
    check("erase_pend", pending_auth_request, exp_pend());
    $display("[TB] erase mask=%b pend=%h", mask, exp_pend());
  endtask

  // One arbitration round: grant, one hold cycle, then Ack_in.
  task automatic rsp_round(input logic [NCH-1:0] mask);
    int g;
    logic [MW-1:0] d;
    g = -1;
    ch_resp_valid = mask;
    for (int k = 0; k < NCH; k++)
      if (g < 0 && mask[(rr + k) % NCH]) g = (rr + k) % NCH;
    tick();
    if (g < 0) begin
      check("rsp_idle_ack", ch_resp_ack, 0);
      check("rsp_idle_ready", auth_msg_ready, 0);
      $display("[TB] rsp mask=%b no grant", mask);
      return;
    end
    check("rsp_grant", ch_resp_ack, 128'd1 << g);
    check("rsp_ready", auth_msg_ready, 1);
    check("rsp_data", auth_msg_out, resp_data[g]);
    d  = resp_data[g];
    rr = (g + 1) % NCH;
    resp_data[g] = $urandom;
    load_resp();
    tick();
    check("rsp_ack_pulse", ch_resp_ack, 0);
    check("rsp_hold_ready", auth_msg_ready, 1);
    check("rsp_hold_data", auth_msg_out, d);
    Ack_in = 1'b1;
    tick();
    Ack_in = 1'b0;
    check("rsp_release", auth_msg_ready, 0);
    check("rsp_no_regrant", ch_resp_ack, 0);
    $display("[TB] rsp mask=%b grant=%0d data=%h", mask, g, d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int g;
    logic [MW-1:0] m;

    reset = 1'b0;
    host_msg_in = '0; host_msg_valid = 1'b0; ch_out_ready = '1;
    pending_auth_request_erase = '0; ch_resp_valid = '0; Ack_in = 1'b0;
    for (int i = 0; i < NCH; i++) begin pend[i] = 0; resp_data[i] = $urandom; end
    load_resp();
    rr = 0; last_msg = '0;
    tick(); tick();
    check("rst_ack", host_msg_ack, 0);
    check("rst_chmsg", ch_msg_out, 0);
    check("rst_chrdy", ch_msg_ready, 0);
    check("rst_pend", pending_auth_request, 0);
    check("rst_rspack", ch_resp_ack, 0);
    check("rst_auth", auth_msg_out, 0);
    check("rst_authrdy", auth_msg_ready, 0);
    check("rst_errs", {err_bad_ch, err_timeout}, 0);
    reset = 1'b1;
    tick();

    // Basic dispatch and bad channel ID
    request(1);
    request(0);
    request(3);

    // Dispatch stalls until the target channel is ready; output holds
    make_msg(2, m);
    ch_out_ready = 3'b011;
    host_msg_in = m; host_msg_valid = 1'b1;
    tick();
    check("stall_ack", host_msg_ack, 1);
    host_msg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_no_disp", ch_msg_ready, 0);
      check("stall_msg_hold", ch_msg_out, last_msg);
    end
    ch_out_ready = '1;
    tick();
    pend[2]++; last_msg = m;
    check("stall_disp", ch_msg_ready, 3'b100);
    check("stall_msg", ch_msg_out, m);
    check("stall_pend", pending_auth_request, exp_pend());
    $display("[TB] req id=2 msg=%h dispatched after stall", m);

    // Saturate ch0, then backpressure until one erase
    while (pend[0] < PMAX) request(0);
    make_msg(0, m);
    host_msg_in = m; host_msg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_no_ack", host_msg_ack, 0);
      check("bp_pend", pending_auth_request, exp_pend());
    end
    pending_auth_request_erase = 3'b001;
    tick();
    pending_auth_request_erase = '0;
    pend[0]--;
    check("bp_erase_pend", pending_auth_request, exp_pend());
    check("bp_still_no_ack", host_msg_ack, 0);
    tick();
    check("bp_ack", host_msg_ack, 1);
    host_msg_valid = 1'b0;
    tick();
    pend[0]++; last_msg = m;
    check("bp_disp", ch_msg_ready, 3'b001);
    check("bp_msg", ch_msg_out, m);
    check("bp_pend_full", pending_auth_request, exp_pend());
    $display("[TB] req id=0 msg=%h dispatched after backpressure", m);

    // Dispatch and erase on the same channel in the same cycle
    erase_mask(3'b001);
    make_msg(0, m);
    ch_out_ready = 3'b110;
    host_msg_in = m; host_msg_valid = 1'b1;
    tick();
    check("same_ack", host_msg_ack, 1);
    host_msg_valid = 1'b0;
    tick();
    check("same_stall", ch_msg_ready, 0);
    ch_out_ready = '1;
    pending_auth_request_erase = 3'b001;
    tick();
    pending_auth_request_erase = '0;
    last_msg = m;
    check("same_disp", ch_msg_ready, 3'b001);
    check("same_pend", pending_auth_request, exp_pend());
    $display("[TB] req id=0 msg=%h dispatched with erase pend=%0d", m, pend[0]);

    // Erase down to zero and once more at zero
    g = pend[1] + 2;
    for (int k = 0; k < g; k++) erase_mask(3'b010);

    // Randomized requests and erases
    for (int n = 0; n < 10; n++) begin
      id = $urandom_range(0, 3);
      if (id < NCH && pend[id] == PMAX) erase_mask(NCH'(1) << id);
      request(id);
      if ($urandom_range(0, 1) == 1) erase_mask(NCH'($urandom_range(0, 7)));
    end

    // Round-robin: all valid gives 0,1,2,0, then random masks
    for (int k = 0; k < 4; k++) rsp_round('1);
    for (int k = 0; k < 8; k++) rsp_round(NCH'($urandom_range(0, 7)));

    // Ack_in with nothing held is ignored
    ch_resp_valid = '0;
    Ack_in = 1'b1;
    tick();
    Ack_in = 1'b0;
    check("stray_ack_ready", auth_msg_ready, 0);
    check("stray_ack_grant", ch_resp_ack, 0);
    rsp_round('1);

    // Long hold without Ack_in
    g = -1;
    ch_resp_valid = 3'b110;
    for (int k = 0; k < NCH; k++)
      if (g < 0 && ch_resp_valid[(rr + k) % NCH]) g = (rr + k) % NCH;
    tick();
    check("hold_grant", ch_resp_ack, 128'd1 << g);
    rr = (g + 1) % NCH;
    ch_resp_valid = '0;
`ifdef AUTH_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      tick();
      check("to_hold_ready", auth_msg_ready, 1);
      check("to_no_err", err_timeout, 0);
    end
    tick();
    check("to_ready_fall", auth_msg_ready, 0);
    check("to_err", err_timeout, 1);
    tick();
    check("to_err_pulse", err_timeout, 0);
    check("to_idle", auth_msg_ready, 0);
    $display("[TB] rsp grant=%0d timed out", g);
`else
    for (int k = 0; k < 12; k++) begin
      tick();
      check("hold_ready", auth_msg_ready, 1);
      check("hold_no_timeout", err_timeout, 0);
    end
    Ack_in = 1'b1;
    tick();
    Ack_in = 1'b0;
    check("hold_release", auth_msg_ready, 0);
    $display("[TB] rsp grant=%0d released after long hold", g);
`endif
    rsp_round('1);

    // Reset with a request stalled in dispatch and a response held
    if (pend[1] == PMAX) erase_mask(3'b010);
    make_msg(1, m);
    ch_out_ready = 3'b101;
    host_msg_in = m; host_msg_valid = 1'b1;
    ch_resp_valid = '1;
    tick();
    check("mid_ack", host_msg_ack, 1);
    check("mid_grant_rdy", auth_msg_ready, 1);
    host_msg_valid = 1'b0; ch_resp_valid = '0;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_ack", host_msg_ack, 0);
    check("mid_rst_chmsg", ch_msg_out, 0);
    check("mid_rst_chrdy", ch_msg_ready, 0);
    check("mid_rst_pend", pending_auth_request, 0);
    check("mid_rst_rspack", ch_resp_ack, 0);
    check("mid_rst_auth", auth_msg_out, 0);
    check("mid_rst_authrdy", auth_msg_ready, 0);
    check("mid_rst_errs", {err_bad_ch, err_timeout}, 0);
    $display("[TB] reset asserted mid-transfer");
    for (int i = 0; i < NCH; i++) pend[i] = 0;
    rr = 0; last_msg = '0;
    ch_out_ready = '1;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_no_disp", ch_msg_ready, 0);
    check("post_rst_pend", pending_auth_request, 0);
    rsp_round('1);
    request(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
